alu_exec_unit: RTL and testbench

//   Execute-stage ALU, directly downstream of the ALU control decoder: consumes
//   its 4-bit ctrl code plus two operands and a shift amount.
//   AND/OR/ADD/SUB complete in one cycle; SLL/SRL run iteratively, one bit per

---
 rtl/alu_exec_unit_if.sv | 29 ++
 rtl/alu_exec_unit.sv | 142 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between the ALU control decoder side and the execute-stage ALU.
// The producer/consumer side uses the master modport, the ALU uses slave.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         ctrl;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               ovf;
  logic               illegal;

  modport master (
    output in_valid, ctrl, op_a, op_b, shamt, out_ready,
    input  in_ready, out_valid, result, zero, ovf, illegal
  );

  modport slave (
    input  in_valid, ctrl, op_a, op_b, shamt, out_ready,
    output in_ready, out_valid, result, zero, ovf, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB, bit-serial SLL/SRL under a
// three-state FSM, valid/ready on both sides.
module alu_exec_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input logic             clk,
  input logic             rst_n,
  alu_exec_unit_if.slave  bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state,   w_state_nxt;
  logic [WIDTH-1:0]   r_work,    w_work_nxt;
  logic [SHAMT_W-1:0] r_cnt,     w_cnt_nxt;
  logic               r_left,    w_left_nxt;
  logic               r_zero,    w_zero_nxt;
  logic               r_ovf,     w_ovf_nxt;
  logic               r_illegal, w_illegal_nxt;
  logic               r_in_ready;
  logic               r_out_valid;

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_a_msb;
  logic               w_b_msb;

  assign w_sum     = bus.op_a + bus.op_b;
  assign w_diff    = bus.op_a - bus.op_b;
  assign w_shifted = r_left ? (r_work << 1) : (r_work >> 1);
  assign w_a_msb   = bus.op_a[WIDTH-1];
  assign w_b_msb   = bus.op_b[WIDTH-1];

  // Next-state and datapath; flags change only on entry to DONE so they stay
  // stable (and reflect the final result only) across a whole shift.
  always_comb begin
    w_state_nxt   = r_state;
    w_work_nxt    = r_work;
    w_cnt_nxt     = r_cnt;
    w_left_nxt    = r_left;
    w_zero_nxt    = r_zero;
    w_ovf_nxt     = r_ovf;
    w_illegal_nxt = r_illegal;

    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_state_nxt   = S_DONE;
          w_ovf_nxt     = 1'b0;
          w_illegal_nxt = 1'b0;
          case (bus.ctrl)
            OP_AND: w_work_nxt = bus.op_a & bus.op_b;
            OP_OR:  w_work_nxt = bus.op_a | bus.op_b;
            OP_ADD: begin
              w_work_nxt = w_sum;
              w_ovf_nxt  = (w_a_msb == w_b_msb) && (w_sum[WIDTH-1] != w_a_msb);
            end
            OP_SUB: begin
              w_work_nxt = w_diff;
              w_ovf_nxt  = (w_a_msb != w_b_msb) && (w_diff[WIDTH-1] != w_a_msb);
            end
            OP_SLL, OP_SRL: begin
              w_work_nxt = bus.op_b;
              w_cnt_nxt  = bus.shamt;
              w_left_nxt = (bus.ctrl == OP_SLL);
              if (bus.shamt != '0) begin
                w_state_nxt   = S_SHIFT;
                w_ovf_nxt     = r_ovf;
                w_illegal_nxt = r_illegal;
              end
            end
            default: begin
              w_work_nxt    = '0;
              w_illegal_nxt = 1'b1;
            end
          endcase
          if (w_state_nxt == S_DONE) begin
            w_zero_nxt = (w_work_nxt == '0);
          end
        end
      end
      S_SHIFT: begin
        w_work_nxt = w_shifted;
        w_cnt_nxt  = r_cnt - SHAMT_W'(1);
        if (r_cnt == SHAMT_W'(1)) begin
          w_state_nxt   = S_DONE;
          w_zero_nxt    = (w_shifted == '0);
          w_ovf_nxt     = 1'b0;
          w_illegal_nxt = 1'b0;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_left      <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_work      <= w_work_nxt;
      r_cnt       <= w_cnt_nxt;
      r_left      <= w_left_nxt;
      r_zero      <= w_zero_nxt;
      r_ovf       <= w_ovf_nxt;
      r_illegal   <= w_illegal_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_work;
  assign bus.zero      = r_zero;
  assign bus.ovf       = r_ovf;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes model results at accept,
// an independent monitor compares every presented output against the queue head.
module tb_alu_exec_unit;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   bp_mode;   // 0: out_ready=1, 1: random, 2: held low

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        il;
    int          exp_cyc;
  } exp_t;

  exp_t q[$];

  alu_exec_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the operation's meaning.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] s);
    exp_t   e;
    longint sa;
    longint sb;
    longint r64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.o = 1'b0;
    e.il = 1'b0;
    e.exp_cyc = 0;
    case (c)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: begin
        r64 = sa + sb;
        e.res = r64[31:0];
        e.o = (r64 > 64'sd2147483647) || (r64 < -64'sd2147483648);
      end
      4'b0100: begin
        r64 = sa - sb;
        e.res = r64[31:0];
        e.o = (r64 > 64'sd2147483647) || (r64 < -64'sd2147483648);
      end
      4'b1000: e.res = b << s;
      4'b1001: e.res = b >> s;
      default: begin
        e.res = 32'h0;
        e.il = 1'b1;
      end
    endcase
    e.z = (e.res == 32'h0);
    return e;
  endfunction

  task automatic issue(input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] s);
    exp_t e;
    int   n;
    bit   done;
    n = 0;
    done = 0;
    @(negedge clk);
    bus.ctrl = c;
    bus.op_a = a;
    bus.op_b = b;
    bus.shamt = s;
    bus.in_valid = 1'b1;
    while (!done) begin
      if (bus.in_ready === 1'b1) begin
        e = model(c, a, b, s);
        e.exp_cyc = cyc + (((c == 4'b1000) || (c == 4'b1001)) ? int'(s) + 1 : 1);
        q.push_back(e);
        done = 1;
      end
      @(posedge clk);
      if (!done) begin
        @(negedge clk);
        n++;
        if (n > 400) begin
          chk("accept_timeout", 64'd0, 64'd1);
          break;
        end
      end
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask

  // Monitor: compare while valid (also proves stability under backpressure).
  bit prev_v;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
      bus.out_ready = 1'b0;
    end else begin
      if (bus.out_valid === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output actual=valid result=%0h required=no output", bus.result);
        end else begin
          chk("result",  64'(bus.result),  64'(q[0].res));
          chk("zero",    64'(bus.zero),    64'(q[0].z));
          chk("ovf",     64'(bus.ovf),     64'(q[0].o));
          chk("illegal", 64'(bus.illegal), 64'(q[0].il));
          chk("in_ready_while_valid", 64'(bus.in_ready), 64'd0);
          if (!prev_v) chk("latency", 64'(cyc), 64'(q[0].exp_cyc));
        end
      end
      prev_v = (bus.out_valid === 1'b1);
      case (bp_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom % 3) != 0;
        default: bus.out_ready = 1'b0;
      endcase
      if (bus.out_valid === 1'b1 && bus.out_ready && q.size() > 0) void'(q.pop_front());
    end
  end

  initial begin
    logic [3:0] ops[7];
    logic [3:0] c;
    logic [4:0] s;
    int         n;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b0111};
    total = 0;
    bad = 0;
    bp_mode = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.ctrl = 4'h0;
    bus.op_a = 32'h0;
    bus.op_b = 32'h0;
    bus.shamt = 5'h0;
    #12;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result",    64'(bus.result),    64'd0);
    chk("rst_flags",     64'({bus.zero, bus.ovf, bus.illegal}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the operation list.
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0);
    issue(4'b0100, 32'd5, 32'd5, 5'd0);
    issue(4'b0000, 32'hF0F0, 32'h0FF0, 5'd0);
    issue(4'b0001, 32'hF0F0, 32'h0FF0, 5'd0);
    issue(4'b1000, 32'h0, 32'h1, 5'd31);
    issue(4'b1001, 32'h0, 32'h8000_0000, 5'd4);
    issue(4'b1000, 32'h0, 32'h1234_5678, 5'd0);
    issue(4'b0111, 32'h1, 32'h2, 5'd0);
    issue(4'b0000, 32'hFFFF_FFFF, 32'h1, 5'd0);
    issue(4'b0100, 32'h8000_0000, 32'h1, 5'd0);
    drain();

    // Backpressure: held result, ignored input, in_ready after handoff.
    bp_mode = 2;
    issue(4'b0010, 32'h1234, 32'h4321, 5'd0);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.ctrl = 4'b0001;
      bus.op_a = $urandom;
      bus.op_b = $urandom;
      bus.in_valid = 1'b1;
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    bp_mode = 0;
    n = 0;
    while (bus.out_valid === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    drain();

    // Randomised traffic with random consumer stalls.
    bp_mode = 1;
    for (int i = 0; i < 60; i++) begin
      c = ops[$urandom_range(0, 6)];
      if (($urandom % 8) == 0) c = 4'($urandom);
      s = (($urandom % 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
      issue(c, $urandom, (($urandom % 5) == 0) ? 32'h0 : $urandom, s);
    end
    drain();
    bp_mode = 0;

    // Reset in the middle of a long shift.
    issue(4'b1000, 32'h0, 32'h1, 5'd20);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_result",    64'(bus.result),    64'd0);
    chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("mid_rst_flags",     64'({bus.zero, bus.ovf, bus.illegal}), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      chk("post_rst_no_valid", 64'(bus.out_valid), 64'd0);
    end
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    issue(4'b0010, 32'hFFFF_FFFF, 32'h1, 5'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
